fifo_ctrl: RTL and testbench

Pointer and flag controller for the synchronous FIFO. It sequences the write-pointer and read-pointer counters and grants or rejects read and write requests. It also maintains the occupancy count and drives the full, empty, almost-full and error status seen by the FIFO's users. It sits between the request interface and the dual-port storage array: its pointer outputs address the RAM, and its grant outputs gate the RAM write and read.

---
 rtl/fifo_ctrl_pkg.sv | 22 ++
 rtl/fifo_ctrl_if.sv | 38 +++
 rtl/fifo_ctrl_counter.sv | 25 ++
 rtl/fifo_ctrl.sv | 88 ++++++++
 tb/tb_fifo_ctrl.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults and the count-update decode for fifo_ctrl.
// ADDR_WIDTH_DEF / ALMOST_FULL_DEF are the parameter defaults used by the
// interface and the controller; cnt_op() turns the two grants into a count op.
package fifo_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF  = 3;
  localparam int ALMOST_FULL_DEF = 6;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Both grants or neither leave the occupancy unchanged.
  function automatic cnt_op_e cnt_op(input logic wr_en, input logic rd_en);
    if (wr_en && !rd_en) return CNT_INC;
    if (rd_en && !wr_en) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/grant/status bundle between FIFO users and fifo_ctrl.
//   wr_req, rd_req         : requests from producer / consumer
//   wr_en, rd_en           : grants (RAM write/read enables)
//   wr_addr, rd_addr       : RAM addresses
//   count, full, empty,
//   almost_full            : registered occupancy status
//   overflow, underflow    : one-cycle error pulses
// master = user side, slave = fifo_ctrl side.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_req, rd_req,
    input  wr_en, rd_en, wr_addr, rd_addr, count,
           full, empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_en, rd_en, wr_addr, rd_addr, count,
           full, empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_counter.sv
// counter: binary up-counter used as a FIFO pointer.
//   clk   : clock
//   en    : advance by one on the rising edge (rolls over naturally)
//   reset : synchronous active-high clear
//   addr  : current count value
module counter
  import fifo_ctrl_pkg::*;
#(
  parameter int COUNTER_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     reset,
  output logic [COUNTER_WIDTH-1:0] addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (en) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a synchronous FIFO.
//   clk   : clock
//   reset : synchronous active-high reset, overrides all requests
//   bus   : fifo_ctrl_if slave modport (requests in; grants, pointers,
//           occupancy, flags and error pulses out)
// Grants come combinationally from registered flags; everything else is
// registered one cycle after the granting edge.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int ALMOST_FULL = ALMOST_FULL_DEF
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(ALMOST_FULL);

  logic                wr_en;
  logic                rd_en;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH:0] count_nxt;
  logic                full_q;
  logic                empty_q;
  logic                af_q;
  logic                ovf_q;
  logic                udf_q;

  // A write while full is refused even if a read is granted alongside it.
  assign wr_en = bus.wr_req & ~full_q  & ~reset;
  assign rd_en = bus.rd_req & ~empty_q & ~reset;

  counter #(.COUNTER_WIDTH(ADDR_WIDTH)) wr_ptr_inst (
    .clk   (clk),
    .en    (wr_en),
    .reset (reset),
    .addr  (bus.wr_addr)
  );

  counter #(.COUNTER_WIDTH(ADDR_WIDTH)) rd_ptr_inst (
    .clk   (clk),
    .en    (rd_en),
    .reset (reset),
    .addr  (bus.rd_addr)
  );

  always_comb begin
    count_nxt = count_q;
    case (cnt_op(wr_en, rd_en))
      CNT_INC: count_nxt = count_q + 1'b1;
      CNT_DEC: count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Flags are derived from count_nxt so they line up with the new count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_C);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_C);
      ovf_q   <= bus.wr_req & full_q;
      udf_q   <= bus.rd_req & empty_q;
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.rd_en       = rd_en;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = af_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = udf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl (ADDR_WIDTH=3, ALMOST_FULL=6).
module tb_fifo_ctrl;

  logic clk;
  logic reset;

  fifo_ctrl_if #(.ADDR_WIDTH(3)) bus ();

  fifo_ctrl #(.ADDR_WIDTH(3), .ALMOST_FULL(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected state, depth 8
  int m_cnt = 0;
  int m_wp  = 0;
  int m_rp  = 0;
  int m_ovf = 0;
  int m_udf = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of requests (called just after a falling edge), check the
  // grants mid-cycle, then check registered state after the next rising edge.
  task automatic step(input logic wr, input logic rd, input logic rst);
    logic ew, er;
    bus.wr_req = wr;
    bus.rd_req = rd;
    reset      = rst;
    #1;
    ew = wr & ~rst & (m_cnt != 8);
    er = rd & ~rst & (m_cnt != 0);
    chk("wr_en", {31'd0, bus.wr_en}, {31'd0, ew});
    chk("rd_en", {31'd0, bus.rd_en}, {31'd0, er});
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_ovf = (wr && m_cnt == 8) ? 1 : 0;
      m_udf = (rd && m_cnt == 0) ? 1 : 0;
      if (ew) m_wp = (m_wp + 1) % 8;
      if (er) m_rp = (m_rp + 1) % 8;
      if (ew && !er) m_cnt++;
      if (er && !ew) m_cnt--;
    end
    @(negedge clk);
    chk("count",       32'(bus.count),       32'(m_cnt));
    chk("wr_addr",     32'(bus.wr_addr),     32'(m_wp));
    chk("rd_addr",     32'(bus.rd_addr),     32'(m_rp));
    chk("full",        32'(bus.full),        (m_cnt == 8) ? 32'd1 : 32'd0);
    chk("empty",       32'(bus.empty),       (m_cnt == 0) ? 32'd1 : 32'd0);
    chk("almost_full", 32'(bus.almost_full), (m_cnt >= 6) ? 32'd1 : 32'd0);
    chk("overflow",    32'(bus.overflow),    32'(m_ovf));
    chk("underflow",   32'(bus.underflow),   32'(m_udf));
  endtask

  initial begin
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    reset      = 1'b1;
    @(negedge clk);

    // reset
    step(1'b0, 1'b0, 1'b1);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);

    // fill
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i + 1));
      chk("fill_af", 32'(bus.almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_wrap", 32'(bus.wr_addr), 32'd0);

    // overflow pulse, then clears
    step(1'b1, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd8);
    step(1'b0, 1'b0, 1'b0);
    chk("ovf_clear", 32'(bus.overflow), 32'd0);

    // drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("drain_count", 32'(bus.count), 32'(7 - i));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_wrap", 32'(bus.rd_addr), 32'd0);

    // underflow pulse, then clears
    step(1'b0, 1'b1, 1'b0);
    chk("udf_pulse", 32'(bus.underflow), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("udf_clear", 32'(bus.underflow), 32'd0);

    // fill to 4, then 5 simultaneous read+write
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    chk("sim_count", 32'(bus.count), 32'd4);
    chk("sim_wp", 32'(bus.wr_addr), 32'd1);
    chk("sim_rp", 32'(bus.rd_addr), 32'd5);

    // to 5, then reset together with a write
    step(1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    step(1'b1, 1'b0, 1'b1);
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_wp", 32'(bus.wr_addr), 32'd0);

    // full with read+write: write refused, read granted, overflow pulses
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("full_rw_count", 32'(bus.count), 32'd7);
    chk("full_rw_ovf", 32'(bus.overflow), 32'd1);

    // empty with read+write: write granted, underflow pulses
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    chk("empty_rw_count", 32'(bus.count), 32'd1);
    chk("empty_rw_udf", 32'(bus.underflow), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
